// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encoding, FSM states and sign-fix helper shared by the mul/div unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int MAX_W = 128;

    // Low bits of a wide two's complement negate equal the narrow negate, so one width serves all callers.
    function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration, shift-add multiply or restoring divide on a packed accumulator.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               i_div,
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_opnd,
    output logic [2*WIDTH-1:0] o_acc
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    logic           w_ge;

    // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
    always_comb begin
        w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
        w_shift = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
        w_diff  = w_shift - {1'b0, i_opnd};
        w_ge    = w_shift >= {1'b0, i_opnd};
        o_acc   = i_div ? {(w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0]), i_acc[WIDTH-2:0], w_ge}
                        : {w_sum, i_acc[WIDTH-1:1]};
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO, MTHI/MTLO, busy/done and cancel.
// Define MULDIV_FAST_MUL_EN for a one-cycle registered array multiply.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e             r_state;
    state_e             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_init;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] w_step;
    logic [2*WIDTH-1:0] w_res;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_done;
    logic               w_sa;
    logic               w_sb;
    logic               w_req;
    logic               w_accept;
    logic               w_final;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] w_prod;
`endif

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_div (r_div),
        .i_acc (r_acc),
        .i_opnd(r_opnd),
        .o_acc (w_step)
    );

    always_comb begin
        w_req        = (r_state == IDLE) && start && !cancel;
        w_accept     = w_req && !op[2];
        w_final      = (r_state == RUN) && !cancel && (r_cnt == '0);
        w_state_next = r_state;
        if (w_accept)
            w_state_next = RUN;
        else if (r_state == RUN && (cancel || r_cnt == '0))
            w_state_next = IDLE;
        w_sa    = !op[0] && a[WIDTH-1];
        w_sb    = !op[0] && b[WIDTH-1];
        w_a_mag = WIDTH'(cond_neg(MAX_W'(a), w_sa));
        w_b_mag = WIDTH'(cond_neg(MAX_W'(b), w_sb));
`ifdef MULDIV_FAST_MUL_EN
        w_cnt_init = op[1] ? CNT_W'(WIDTH - 1) : '0;
        w_prod     = {{WIDTH{1'b0}}, r_opnd} * {{WIDTH{1'b0}}, r_acc[WIDTH-1:0]};
        w_res      = r_div ? w_step : w_prod;
`else
        w_cnt_init = CNT_W'(WIDTH - 1);
        w_res      = w_step;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_opnd  <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_final;
            if (w_req && op == OP_MTHI)
                r_hi <= a;
            if (w_req && op == OP_MTLO)
                r_lo <= a;
            if (w_accept) begin
                r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
                r_opnd  <= w_b_mag;
                r_div   <= op[1];
                // Divide by zero leaves quotient all ones and lets the remainder rebuild a.
                r_neg_q <= (w_sa ^ w_sb) && !(op[1] && b == '0);
                r_neg_r <= w_sa;
                r_cnt   <= w_cnt_init;
            end else if (r_state == RUN) begin
                r_acc <= w_step;
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_final) begin
                if (r_div) begin
                    r_lo <= WIDTH'(cond_neg(MAX_W'(w_res[WIDTH-1:0]), r_neg_q));
                    r_hi <= WIDTH'(cond_neg(MAX_W'(w_res[2*WIDTH-1:WIDTH]), r_neg_r));
                end else begin
                    {r_hi, r_lo} <= (2*WIDTH)'(cond_neg(MAX_W'(w_res), r_neg_q));
                end
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: vector table through a scoreboard plus hand sequences for MT*, cancel and reset.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         cancel;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .cancel(cancel),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] eh, input logic [W-1:0] el, input string name);
        exp_t e;
        int   n;
        op = o; a = x; b = y; start = 1'b1;
        e.hi = eh; e.lo = el;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk({name, " latency"}, 64'(n), 64'(o[1] ? W : MUL_LAT));
        chk({name, " done"}, 64'(done), 64'd1);
        if (done && sb.size() > 0) begin
            e = sb.pop_front();
            chk({name, " hi"}, 64'(hi), 64'(e.hi));
            chk({name, " lo"}, 64'(lo), 64'(e.lo));
        end
        @(negedge clk);
        chk({name, " done pulse"}, 64'(done), 64'd0);
    endtask

    task automatic mt(input logic [2:0] o, input logic [W-1:0] x);
        op = o; a = x; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int seen;
        reset = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
        vecs[0]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{OP_DIVU,  32'd100,      32'h00000000, 32'd100,      32'hFFFFFFFF};
        vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[6]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[7]  = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000003, 32'h00000000, 32'h55555555};
        vecs[8]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9]  = '{OP_MULT,  32'd12345,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFCFC7};
        vecs[10] = '{OP_DIVU,  32'd1000,     32'd7,        32'd6,        32'd142};
        vecs[11] = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

        repeat (2) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));

        mt(OP_MTHI, 32'h12345678);
        chk("mthi hi", 64'(hi), 64'h12345678);
        chk("mthi busy", 64'(busy), 64'd0);
        chk("mthi done", 64'(done), 64'd0);
        mt(OP_MTLO, 32'hCAFEBABE);
        chk("mtlo lo", 64'(lo), 64'hCAFEBABE);
        chk("mtlo hi kept", 64'(hi), 64'h12345678);

        op = OP_DIV; a = 32'd50; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("cancel busy before", 64'(busy), 64'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel busy", 64'(busy), 64'd0);
        chk("cancel done", 64'(done), 64'd0);
        chk("cancel hi", 64'(hi), 64'h12345678);
        chk("cancel lo", 64'(lo), 64'hCAFEBABE);
        seen = 0;
        repeat (W + 2) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("cancel quiet", 64'(seen), 64'd0);

        op = OP_MTHI; a = 32'h0000DEAD; start = 1'b1; cancel = 1'b1;
        @(negedge clk);
        op = OP_DIV; b = 32'd1;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        chk("cancel+start hi", 64'(hi), 64'h12345678);
        chk("cancel+start busy", 64'(busy), 64'd0);
        mt(3'd6, 32'h0BADF00D);
        chk("reserved busy", 64'(busy), 64'd0);
        chk("reserved hi", 64'(hi), 64'h12345678);
        chk("reserved lo", 64'(lo), 64'hCAFEBABE);

        run_op(OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, "multu 3x5");

        mt(OP_MTHI, 32'hA5A5A5A5);
        op = OP_MULT; a = 32'hFFFFFFFD; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (MUL_LAT > 1 ? 5 : 0) @(negedge clk);
        chk("mid busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid reset busy", 64'(busy), 64'd0);
        chk("mid reset hi", 64'(hi), 64'd0);
        chk("mid reset lo", 64'(lo), 64'd0);
        chk("mid reset done", 64'(done), 64'd0);
        @(negedge clk);
        chk("post reset done", 64'(done), 64'd0);

        run_op(OP_DIVU, 32'd81, 32'd9, 32'd0, 32'd9, "divu after reset");
        chk("scoreboard empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with private HI/LO registers, attached to the EX stage of the 5-stage pipelined CPU. It executes MULT/MULTU/DIV/DIVU over multiple cycles and MTHI/MTLO in one cycle. It exposes a busy/done handshake, which the hazard unit uses to stall MFHI/MFLO and back-to-back mul/div issue. A cancel input discards an in-flight operation when an interrupt or exception flushes EX.

## Interface
- WIDTH, 32: operand width; HI and LO are each WIDTH bits; minimum 4.
- CNT_W, $clog2(WIDTH)+1: iteration counter width (derived, not overridden).
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; overrides every other input.
- start  in  1  one-cycle request from EX; sampled only when busy=0.
- op  in  3  operation code from the shared package: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- a  in  WIDTH  rs operand (forwarded EX value).
- b  in  WIDTH  rt operand (forwarded EX value).
- cancel  in  1  flush of the EX instruction; aborts the in-flight op.
- busy  out  1  high while an operation is iterating.
- done  out  1  one-cycle pulse after HI/LO receive a mul/div result.
- hi  out  WIDTH  HI register, direct register output.
- lo  out  WIDTH  LO register, direct register output.

## Operation
- States are IDLE and RUN. busy = (state==RUN).
- IDLE with start=1 and op=MTHI or MTLO: hi<=a or lo<=a at that edge. State stays IDLE, done stays 0.
- IDLE with start=1 and a mul/div op: latch |a| and |b| (signed ops) or a and b (unsigned ops). Latch the result signs. Set cnt<=WIDTH-1 and enter RUN.
- Multiply: shift-add, radix-2, one partial product per cycle. The accumulator is 2*WIDTH bits.
- Divide: restoring, one quotient bit per cycle. The remainder is WIDTH+1 bits.
- RUN: one step per cycle and cnt decrements. The step with cnt==0 is final. On that edge:
  - Apply the sign fix and write HI/LO.
  - Set state<=IDLE and done<=1.
- Signed results: the product is negated if sign(a)≠sign(b). The quotient is negated likewise. The remainder takes sign(a).
- Divide by zero (b==0): HI<=a and LO<=all ones, for both signed and unsigned. It still takes the full WIDTH cycles.
- Signed overflow, most-negative÷−1: LO<=most-negative and HI<=0. No trap is raised.
- start while busy=1 is ignored; the hazard unit guarantees it does not occur.
- cancel=1 in RUN: state<=IDLE next edge, HI/LO unchanged, no done.
- cancel=1 in IDLE together with start: the request is discarded.
- cancel has priority over the final step.
- reset=1: state=IDLE, hi=0, lo=0, busy=0, done=0, cnt=0. This applies mid-operation too.

## Timing
- Mul/div start accepted at edge T: busy=1 from T through T+WIDTH-1 edges, i.e. WIDTH cycles high.
- HI/LO are valid and done=1 after edge T+WIDTH. busy falls at that same edge.
- A new mul/div may be accepted at edge T+WIDTH+1, when busy is 0 at sampling.
- MTHI/MTLO latency is one edge, with no busy.
- done is high for exactly one cycle.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - MULT/MULTU use a registered array multiply.
  - busy is high for one cycle and the result plus done follow at edge T+1.
  - DIV/DIVU timing is unchanged.
- MULDIV_FAST_MUL_EN undefined: the iterative multiply above, WIDTH cycles.

## Structure
- muldiv_pkg holds:
  - the op encoding: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5, others reserved and treated as no-op;
  - the state enum IDLE/RUN;
  - the helper function for the sign fix.
- One sub-module, muldiv_step: combinational single-iteration datapath (add-shift or subtract-shift) selected by a mul/div bit. Its state is instantiated once inside muldiv_unit.

## Test plan
- Default WIDTH=32, MULT a=0xFFFFFFFD (−3), b=7 -> busy 32 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB, done one cycle.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=−7, b=2 -> lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1); DIVU a=100, b=0 -> hi=100, lo=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x12345678, then cancel at cycle 10 of a DIV -> hi stays 0x12345678, busy low next cycle, no done; a following MULTU 3×5 gives lo=15.
- reset asserted mid-MULT -> busy=0, hi=lo=0 next edge; rerun with WIDTH=8, and also with MULDIV_FAST_MUL_EN, to check the one-cycle multiply latency.
